uart_echo_core: RTL and testbench

Self-contained UART loopback responder that sits at the device pins (RX in, TX out) on a single 100 MHz clock. Every correctly framed 8N1 byte received on RX is re-transmitted unchanged on TX, in arrival order, at the same baud rate. A small FIFO between receiver and transmitter absorbs back-to-back input.

---
 rtl/uart_echo_core.sv | 178 +++++++++++++++++
 tb/tb_uart_echo_core.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_core.sv
// uart_echo_core: 8N1 receiver -> byte FIFO -> 8N1 transmitter. Every correctly
// framed byte arriving on RX is sent back out on TX, in order, at the same rate.
`timescale 1ns/1ps
module uart_echo_core #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic RX,
  output logic TX
);
  localparam int DIV   = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  // 16x oversample tick, registered so the first one lands DIV clocks after reset
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // RX synchronizer, idles high so reset never looks like a start bit
  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
    end
  end

  uart_state_t rx_state;
  uart_state_t rx_next;
  logic [3:0]  rx_tcnt;
  logic [2:0]  rx_bcnt;
  logic [7:0]  rx_shift;
  logic        rx_half;
  logic        rx_bit_end;
  logic        push;

  assign rx_half    = tick && (rx_tcnt == 4'd7);
  assign rx_bit_end = tick && (rx_tcnt == 4'd15);

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      ST_IDLE:  if (!rx_sync) rx_next = ST_START;
      ST_START: if (rx_half) rx_next = rx_sync ? ST_IDLE : ST_DATA;
      ST_DATA:  if (rx_bit_end && (rx_bcnt == 3'd7)) rx_next = ST_STOP;
      ST_STOP:  if (rx_bit_end) rx_next = ST_IDLE;
      default:  rx_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_state <= ST_IDLE;
      rx_tcnt  <= '0;
      rx_bcnt  <= '0;
      rx_shift <= '0;
      push     <= 1'b0;
    end else begin
      rx_state <= rx_next;
      push     <= 1'b0;
      if (rx_state != rx_next) rx_tcnt <= '0;
      else if (tick)           rx_tcnt <= rx_tcnt + 1'b1;
      if (rx_state == ST_IDLE) rx_bcnt <= '0;
      if ((rx_state == ST_DATA) && rx_bit_end) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bcnt  <= rx_bcnt + 1'b1;
      end
      // A low stop bit is a framing error: the byte is simply never pushed
      if ((rx_state == ST_STOP) && rx_bit_end && rx_sync) push <= 1'b1;
    end
  end

  // Echo FIFO with an extra wrap bit on each pointer
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        wr_en;
  logic        pop;
  logic [7:0]  rd_data;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en   = push && !full;
  assign rd_data = fifo_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (wr_en) begin
        fifo_mem[wr_ptr[AW-1:0]] <= rx_shift;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  uart_state_t tx_state;
  uart_state_t tx_next;
  logic [3:0]  tx_tcnt;
  logic [2:0]  tx_bcnt;
  logic [7:0]  tx_shift;
  logic        tx_bit_end;

  assign tx_bit_end = tick && (tx_tcnt == 4'd15);

  always_comb begin
    tx_next = tx_state;
    pop     = 1'b0;
    case (tx_state)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          tx_next = ST_START;
        end
      end
      ST_START: if (tx_bit_end) tx_next = ST_DATA;
      ST_DATA:  if (tx_bit_end && (tx_bcnt == 3'd7)) tx_next = ST_STOP;
      ST_STOP:  if (tx_bit_end) tx_next = ST_IDLE;
      default:  tx_next = ST_IDLE;
    endcase
  end

  // TX comes straight from a flop, one clock behind the FSM state
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tx_state <= ST_IDLE;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_shift <= '0;
      TX       <= 1'b1;
    end else begin
      tx_state <= tx_next;
      if (tx_state != tx_next) tx_tcnt <= '0;
      else if (tick)           tx_tcnt <= tx_tcnt + 1'b1;
      if (tx_state == ST_IDLE) tx_bcnt <= '0;
      if (pop) tx_shift <= rd_data;
      if ((tx_state == ST_DATA) && tx_bit_end) begin
        tx_shift <= {1'b1, tx_shift[7:1]};
        tx_bcnt  <= tx_bcnt + 1'b1;
      end
      case (tx_state)
        ST_START: TX <= 1'b0;
        ST_DATA:  TX <= tx_shift[0];
        default:  TX <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_core.sv
// Bench for uart_echo_core: drives 8N1 frames on RX, decodes TX with an
// independent UART monitor, and scores echoes against a queue of expected bytes.
`timescale 1ns/1ps
module tb_uart_echo_core;
  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 3_125_000;
  localparam int DEPTH    = 2;
  localparam int DIV      = 2;
  localparam int BIT      = 16 * DIV;
  localparam int OVF_N    = 130;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  logic RX    = 1'b1;
  logic TX;

  uart_echo_core #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .RX   (RX),
    .TX   (TX)
  );

  always #5 CLK = ~CLK;

  int         checks = 0;
  int         errors = 0;
  int         frames = 0;
  longint     cyc = 0;
  longint     last_rx_fall = 0;
  bit         ovf_mode = 1'b0;
  bit         rst_hit = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  longint     tx_starts[$];

  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge RESET) rst_hit = 1'b1;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int ticks);
    RX = b;
    repeat (ticks * DIV) @(posedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_val, input int stop_ticks,
                           input bit expect_echo);
    if (expect_echo) exp_q.push_back(d);
    last_rx_fall = cyc;
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
    send_bit(stop_val, stop_ticks);
    RX = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge CLK);
      n++;
    end
    check(tag, longint'(exp_q.size()), 0);
    repeat (BIT) @(posedge CLK);
  endtask

  // TX line monitor: mid-bit sampling, pops the scoreboard at each stop bit
  initial begin
    logic [7:0] data;
    logic       stop_b;
    forever begin
      @(negedge CLK);
      if (RESET === 1'b1 && TX === 1'b0) begin
        rst_hit = 1'b0;
        tx_starts.push_back(cyc);
        repeat (BIT / 2) @(negedge CLK);
        if (!rst_hit) check("tx_start_bit", longint'(TX), 0);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge CLK);
          data[i] = TX;
        end
        repeat (BIT) @(negedge CLK);
        stop_b = TX;
        if (!rst_hit) begin
          frames++;
          check("echo_stop", longint'(stop_b), 1);
          if (ovf_mode) got_q.push_back(data);
          else begin
            check("echo_expected", longint'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("echo_data", longint'(data), longint'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    repeat (200000) @(posedge CLK);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int     lows;
    int     n;
    int     quiet;
    int     viol;
    int     drops;
    longint lat;

    // Reset with RX idle
    RESET = 1'b0;
    RX    = 1'b1;
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    check("reset_tx_high", longint'(TX), 1);
    #2 RESET = 1'b1;
    lows = 0;
    repeat (2000) @(negedge CLK) if (TX !== 1'b1) lows++;
    check("idle_after_reset", longint'(lows), 0);
    check("idle_no_frames", longint'(frames), 0);

    // Single byte with latency
    frames = 0;
    tx_starts.delete();
    send_byte(8'h41, 1'b1, 16, 1'b1);
    drain("single_drain", 2000);
    check("single_frames", longint'(frames), 1);
    check("single_start_seen", longint'(tx_starts.size()), 1);
    if (tx_starts.size() > 0) begin
      lat = tx_starts[0] - last_rx_fall;
      check("single_latency_in_range", longint'(lat >= 9 * BIT && lat <= 10 * BIT), 1);
    end

    // Back-to-back burst
    frames = 0;
    tx_starts.delete();
    for (int i = 0; i < 5; i++) send_byte(8'h41 + 8'(i), 1'b1, 16, 1'b1);
    drain("burst_drain", 4000);
    check("burst_frames", longint'(frames), 5);
    if (tx_starts.size() == 5)
      check("burst_contiguous", longint'(tx_starts[4] - tx_starts[0] <= 4 * (10 * BIT + 4)), 1);

    // Framing error discards only the bad byte
    frames = 0;
    send_byte(8'h55, 1'b0, 12, 1'b0);
    send_bit(1'b1, 32);
    send_byte(8'h5A, 1'b1, 16, 1'b1);
    drain("framing_drain", 2000);
    check("framing_frames", longint'(frames), 1);

    // Short glitch, then 0x00 and 0xFF
    frames = 0;
    RX = 1'b0;
    repeat (4 * DIV) @(posedge CLK);
    RX = 1'b1;
    repeat (4 * BIT) @(posedge CLK);
    check("glitch_no_echo", longint'(frames), 0);
    send_byte(8'h00, 1'b1, 16, 1'b1);
    send_byte(8'hFF, 1'b1, 16, 1'b1);
    drain("glitch_drain", 3000);
    check("glitch_frames", longint'(frames), 2);

    // Reset in the middle of a received frame
    frames = 0;
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    #2 RESET = 1'b0;
    RX = 1'b1;
    repeat (4) @(posedge CLK);
    #2 RESET = 1'b1;
    repeat (20 * BIT) @(posedge CLK);
    check("rx_abort_no_echo", longint'(frames), 0);
    send_byte(8'h3C, 1'b1, 16, 1'b1);
    drain("rx_abort_recover", 2000);
    check("rx_abort_frames", longint'(frames), 1);

    // Reset during a transmitted start bit
    frames = 0;
    send_byte(8'hC3, 1'b1, 16, 1'b1);
    n = 0;
    while (TX !== 1'b0 && n < 600) begin
      @(negedge CLK);
      n++;
    end
    check("tx_busy_before_reset", longint'(TX), 0);
    #2 RESET = 1'b0;
    #1 check("tx_async_high", longint'(TX), 1);
    exp_q.delete();
    repeat (4) @(posedge CLK);
    #2 RESET = 1'b1;
    repeat (20 * BIT) @(posedge CLK);
    check("tx_abort_no_resume", longint'(frames), 0);

    // Overflow: short stop bits make input outpace the transmitter
    ovf_mode = 1'b1;
    got_q.delete();
    for (int i = 0; i < OVF_N; i++) send_byte(8'(i), 1'b1, 12, 1'b0);
    quiet = 0;
    n = 0;
    while (quiet < 40 * BIT && n < 20000) begin
      @(negedge CLK);
      n++;
      if (TX === 1'b1) quiet++;
      else quiet = 0;
    end
    check("ovf_quiet", longint'(quiet >= 40 * BIT), 1);
    for (int i = 0; i <= DEPTH; i++)
      check("ovf_head", (got_q.size() > i) ? longint'(got_q[i]) : -1, longint'(i));
    viol = 0;
    for (int i = 1; i < got_q.size(); i++)
      if (got_q[i] <= got_q[i-1] || got_q[i] >= 8'(OVF_N)) viol++;
    check("ovf_order", longint'(viol), 0);
    drops = OVF_N - got_q.size();
    check("ovf_dropped_some", longint'(drops >= 1), 1);
    check("ovf_drop_bound", longint'(drops <= OVF_N / 20), 1);
    ovf_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
